// File: rtl/alu_serial.sv
// ---------------------------------------------------------------------------
// alu_serial
//   Bit-serial ALU: one operand bit per clock, LSB first, through a single
//   full-adder slice and one carry flop. Valid/ready handshake on both sides.
//
//   Optional feature macro: ALU_FLAGS_EN adds the zf_o / nf_o / vf_o flag
//   outputs (zero, negative, signed overflow). Without it they are absent.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   in_valid_i   op/a/b/cin valid           in_ready_o   accepting (IDLE only)
//   op_i[3:0]    opcode                     a_i, b_i     operands
//   cin_i        carry-in (ADC/SBC)
//   out_valid_o  result valid (DONE)        out_ready_i  consumer takes result
//   y_o          result                     cout_o       carry-out (1 = no borrow)
//   zf_o/nf_o/vf_o   flags (ALU_FLAGS_EN only)
//
// States
//   IDLE | waiting for an operation, in_ready_o=1
//   RUN  | shifting WIDTH operand bits through the adder slice
//   DONE | result held on y_o/cout_o until out_ready_i
// ---------------------------------------------------------------------------
module alu_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] y_o,
    output logic             cout_o
`ifdef ALU_FLAGS_EN
    ,
    output logic             zf_o,
    output logic             nf_o,
    output logic             vf_o
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] y_sh_q, y_sh_d;
    logic [3:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic is_arith, is_sub, a_bit, b_eff, sum_bit, carry_nxt, res_bit, last_bit;

    // Single full-adder slice plus the per-bit logic functions.
    always_comb begin
        is_arith  = (op_q[3:2] == 2'b00);
        is_sub    = op_q[1];                 // SUB/SBC feed ~b into the adder
        a_bit     = a_sh_q[0];
        b_eff     = b_sh_q[0] ^ is_sub;
        sum_bit   = a_bit ^ b_eff ^ carry_q;
        carry_nxt = (a_bit & b_eff) | (carry_q & (a_bit ^ b_eff));
        last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
        case (op_q)
            4'd0, 4'd1, 4'd2, 4'd3: res_bit = sum_bit;
            4'd4:    res_bit = a_bit & b_sh_q[0];
            4'd5:    res_bit = a_bit | b_sh_q[0];
            4'd6:    res_bit = a_bit ^ b_sh_q[0];
            4'd7:    res_bit = ~(a_bit | b_sh_q[0]);
            4'd8:    res_bit = ~(a_bit & b_sh_q[0]);
            4'd9:    res_bit = ~a_bit;
            4'd10:   res_bit = b_sh_q[0];
            default: res_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        y_sh_d  = y_sh_q;
        op_d    = op_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    op_d    = op_i;
                    case (op_i)
                        4'd1, 4'd3: carry_d = cin_i;
                        4'd2:       carry_d = 1'b1;
                        default:    carry_d = 1'b0;
                    endcase
                end
            end
            S_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                y_sh_d  = {res_bit, y_sh_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                carry_d = is_arith ? carry_nxt : carry_q;
                if (last_bit) begin
                    state_d = S_DONE;
                    cout_d  = is_arith ? carry_nxt : 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            y_sh_q  <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            y_sh_q  <= y_sh_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign y_o         = y_sh_q;
    assign cout_o      = cout_q;

`ifdef ALU_FLAGS_EN
    logic zf_q, nf_q, vf_q;

    // Flags are captured from the final bit-cycle: vf compares the carry
    // entering the MSB slice with the carry leaving it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            zf_q <= 1'b0;
            nf_q <= 1'b0;
            vf_q <= 1'b0;
        end else if (state_q == S_RUN && last_bit) begin
            zf_q <= (y_sh_d == '0);
            nf_q <= res_bit;
            vf_q <= is_arith ? (carry_q ^ carry_nxt) : 1'b0;
        end
    end

    assign zf_o = zf_q;
    assign nf_o = nf_q;
    assign vf_o = vf_q;
`endif

endmodule

// File: tb/tb_alu_serial.sv
module tb_alu_serial;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [3:0]   op_i;
    logic [W-1:0] a_i, b_i;
    logic         cin_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] y_o;
    logic         cout_o;
`ifdef ALU_FLAGS_EN
    logic         zf_o, nf_o, vf_o;
`endif

    alu_serial #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .y_o         (y_o),
        .cout_o      (cout_o)
`ifdef ALU_FLAGS_EN
        ,
        .zf_o        (zf_o),
        .nf_o        (nf_o),
        .vf_o        (vf_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] y;
        logic         cout;
        logic         zf;
        logic         nf;
        logic         vf;
    } exp_t;

    exp_t         exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] last_y;
    logic         last_cout;
    logic [2:0]   last_fl;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the operands.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t         r;
        logic [W:0]   s;
        logic [W-1:0] bb;
        logic         c0;
        r = '0;
        bb = b;
        c0 = 1'b0;
        if (op <= 4'd3) begin
            case (op)
                4'd0: begin bb = b;  c0 = 1'b0; end
                4'd1: begin bb = b;  c0 = cin;  end
                4'd2: begin bb = ~b; c0 = 1'b1; end
                default: begin bb = ~b; c0 = cin; end
            endcase
            s      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
            r.y    = s[W-1:0];
            r.cout = s[W];
            r.vf   = (a[W-1] == bb[W-1]) && (r.y[W-1] != a[W-1]);
        end else begin
            case (op)
                4'd4:  r.y = a & b;
                4'd5:  r.y = a | b;
                4'd6:  r.y = a ^ b;
                4'd7:  r.y = ~(a | b);
                4'd8:  r.y = ~(a & b);
                4'd9:  r.y = ~a;
                4'd10: r.y = b;
                default: r.y = '0;
            endcase
        end
        r.zf = (r.y == '0);
        r.nf = r.y[W-1];
        return r;
    endfunction

    // Every cycle a result is presented, it must match the model.
    always @(negedge clk) begin
        if (!rst_i && out_valid_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got 1, expected 0");
            end else begin
                chk("model_y", y_o, exp_q[0].y);
                chk("model_cout", cout_o, exp_q[0].cout);
`ifdef ALU_FLAGS_EN
                chk("model_flags", {zf_o, nf_o, vf_o}, {exp_q[0].zf, exp_q[0].nf, exp_q[0].vf});
`endif
            end
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input int hold);
        bit acc;
        int lat;
        @(negedge clk);
        op_i = op; a_i = a; b_i = b; cin_i = c; in_valid_i = 1'b1;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready_o) begin
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            in_valid_i = 1'b0;
            return;
        end
        exp_q.push_back(model(op, a, b, c));
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("in_ready_in_run", in_ready_o, 0);
        lat = 0;
        while (!out_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, W);
        if (!out_valid_o) begin
            exp_q.delete();
            return;
        end
        last_y    = y_o;
        last_cout = cout_o;
`ifdef ALU_FLAGS_EN
        last_fl   = {zf_o, nf_o, vf_o};
`else
        last_fl   = 3'b000;
`endif
        // Stall the consumer while offering a new op that must be ignored.
        for (int i = 0; i < hold; i++) begin
            in_valid_i = 1'b1;
            op_i = 4'd0; a_i = 16'h1111; b_i = 16'h2222;
            @(negedge clk);
            chk("in_ready_in_done", in_ready_o, 0);
            chk("out_valid_held", out_valid_o, 1);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        exp_q.pop_front();
        chk("out_valid_after_hs", out_valid_o, 0);
        chk("in_ready_after_hs", in_ready_o, 1);
    endtask

    task automatic run_vec(input string name, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic c,
                           input logic [W-1:0] ey, input logic ec, input int hold);
        do_op(op, a, b, c, hold);
        chk({name, "_y"}, last_y, ey);
        chk({name, "_cout"}, last_cout, ec);
    endtask

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        op_i = '0; a_i = '0; b_i = '0; cin_i = 1'b0;
        last_y = '0; last_cout = 1'b0; last_fl = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_y", y_o, 0);
        chk("rst_cout", cout_o, 0);

        run_vec("add_00ff", 4'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0);
        run_vec("sub_5_7",  4'd2, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 0);
`ifdef ALU_FLAGS_EN
        chk("sub_5_7_nf_vf", {last_fl[1], last_fl[0]}, 2'b10);
`endif
        run_vec("sbc_c0",   4'd3, 16'h0005, 16'h0007, 1'b0, 16'hFFFD, 1'b0, 0);
        run_vec("sbc_c1",   4'd3, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 0);
        run_vec("add_ovf",  4'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0);
`ifdef ALU_FLAGS_EN
        chk("add_ovf_vf", last_fl[0], 1);
`endif
        run_vec("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
`ifdef ALU_FLAGS_EN
        chk("add_wrap_zf", last_fl[2], 1);
`endif
        run_vec("adc_c1",   4'd1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 0);
        run_vec("sub_ovf",  4'd2, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 0);
        run_vec("and",  4'd4,  16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 0);
        run_vec("or",   4'd5,  16'hF0F0, 16'hFF00, 1'b1, 16'hFFF0, 1'b0, 0);
        run_vec("xor",  4'd6,  16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0, 1'b0, 0);
        run_vec("nor",  4'd7,  16'hF0F0, 16'hFF00, 1'b0, 16'h000F, 1'b0, 0);
        run_vec("nand", 4'd8,  16'hF0F0, 16'hFF00, 1'b0, 16'h0FFF, 1'b0, 0);
        run_vec("not",  4'd9,  16'hF0F0, 16'hFF00, 1'b0, 16'h0F0F, 1'b0, 0);
        run_vec("pass", 4'd10, 16'hF0F0, 16'hFF00, 1'b0, 16'hFF00, 1'b0, 0);
        run_vec("op12", 4'd12, 16'hF0F0, 16'hFF00, 1'b1, 16'h0000, 1'b0, 0);

        // Consumer stall in DONE, with a competing request present.
        run_vec("hold_add", 4'd0, 16'h1000, 16'h2345, 1'b0, 16'h3345, 1'b0, 5);

        // Reset in the middle of RUN aborts the op.
        @(negedge clk);
        op_i = 4'd0; a_i = 16'h1234; b_i = 16'h1111; cin_i = 1'b0; in_valid_i = 1'b1;
        chk("abort_accept_ready", in_ready_o, 1);
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_in_run", out_valid_o, 0);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        exp_q.delete();
        chk("abort_in_ready", in_ready_o, 1);
        chk("abort_out_valid", out_valid_o, 0);
        chk("abort_y", y_o, 0);
        repeat (20) @(negedge clk);
        chk("abort_no_emit", out_valid_o, 0);
        run_vec("post_abort", 4'd2, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b1, 2);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
